// File: rtl/bram_mbox_pkg.sv
// rtl/bram_mbox_pkg.sv - shared constants and FSM state type for the BRAM mailbox reader
package bram_mbox_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RD_HDR    = 4'd1,
    S_WAIT_HDR  = 4'd2,
    S_CHECK     = 4'd3,
    S_RD_PAY    = 4'd4,
    S_WR_SUM    = 4'd5,
    S_WR_XOR    = 4'd6,
    S_WR_STATUS = 4'd7,
    S_CLR_HDR   = 4'd8
  } state_e;

  localparam int HDR_ADDR        = 0;
  localparam int HDR_VALID_BIT   = 31;
  localparam int LEN_MSB         = 10;
  localparam int LEN_W           = LEN_MSB + 1;

  localparam int STATUS_DONE_BIT = 31;
  localparam int STATUS_ERR_BIT  = 30;

  localparam int RESP_SUM_OFS    = 0;
  localparam int RESP_XOR_OFS    = 1;
  localparam int RESP_STATUS_OFS = 2;

endpackage

// File: rtl/bram_mbox_accum.sv
// rtl/bram_mbox_accum.sv - running 32-bit sum and XOR over accepted payload words
module bram_mbox_accum #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] sum,
  output logic [DATA_WIDTH-1:0] xr
);

  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] xr_q, xr_d;

  always_comb begin
    sum_d = sum_q;
    xr_d  = xr_q;
    if (clr) begin
      sum_d = '0;
      xr_d  = '0;
    end else if (en) begin
      sum_d = sum_q + data;
      xr_d  = xr_q ^ data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      xr_q  <= '0;
    end else begin
      sum_q <= sum_d;
      xr_q  <= xr_d;
    end
  end

  assign sum = sum_q;
  assign xr  = xr_q;

endmodule

// File: rtl/bram_mailbox_reader.sv
// rtl/bram_mailbox_reader.sv - polls the shared BRAM mailbox over port B, sums/XORs the payload
// and posts a response block before handing word 0 back to the producer.
module bram_mailbox_reader
  import bram_mbox_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 11,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    READ_LATENCY  = 1,
  parameter logic [ADDR_WIDTH-1:0] RESP_BASE     = 11'h400,
  parameter int                    MAX_LEN       = 1023,
  parameter int                    POLL_INTERVAL = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] bram_portb_addr,
  output logic                  bram_portb_en,
  output logic                  bram_portb_we,
  output logic [DATA_WIDTH-1:0] bram_portb_din,
  input  logic [DATA_WIDTH-1:0] bram_portb_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [3:0]            led_out
);

  localparam int PCW = $clog2(POLL_INTERVAL + 1);

  state_e                  state_q, state_d;
  logic [PCW-1:0]          poll_cnt_q, poll_cnt_d;
  logic [1:0]              wait_q, wait_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        iss_cnt_q, iss_cnt_d;
  logic [LEN_W-1:0]        rcv_cnt_q, rcv_cnt_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic [3:0]              led_q, led_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;

  logic                    len_ok;
  logic                    pay_issue;
  logic                    acc_clr;
  logic                    acc_en;
  logic [DATA_WIDTH-1:0]   sum;
  logic [DATA_WIDTH-1:0]   xr;
  logic [DATA_WIDTH-1:0]   status_w;

  assign len_ok    = (len_q != '0) && (len_q <= LEN_W'(MAX_LEN));
  assign pay_issue = (state_q == S_RD_PAY) && (iss_cnt_q != len_q);
  assign acc_clr   = (state_q == S_CHECK) && len_ok;
  // The valid pipe lines each issued payload read up with its returning data word.
  assign acc_en    = vld_q[READ_LATENCY-1];

  bram_mbox_accum #(.DATA_WIDTH(DATA_WIDTH)) u_accum (
    .clk  (clk),
    .rst  (rst),
    .clr  (acc_clr),
    .en   (acc_en),
    .data (bram_portb_dout),
    .sum  (sum),
    .xr   (xr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      poll_cnt_q <= '0;
      wait_q     <= '0;
      len_q      <= '0;
      iss_cnt_q  <= '0;
      rcv_cnt_q  <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      led_q      <= '0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      wait_q     <= wait_d;
      len_q      <= len_d;
      iss_cnt_q  <= iss_cnt_d;
      rcv_cnt_q  <= rcv_cnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      led_q      <= led_d;
      vld_q      <= vld_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    poll_cnt_d = '0;
    wait_d     = '0;
    len_d      = len_q;
    iss_cnt_d  = iss_cnt_q;
    rcv_cnt_d  = rcv_cnt_q;
    err_d      = err_q;
    busy_d     = busy_q;
    led_d      = led_q;
    vld_d[0]   = pay_issue;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    unique case (state_q)
      S_IDLE: begin
        if (poll_cnt_q == PCW'(POLL_INTERVAL - 1)) state_d = S_RD_HDR;
        else poll_cnt_d = poll_cnt_q + 1'b1;
      end
      S_RD_HDR: state_d = S_WAIT_HDR;
      S_WAIT_HDR: begin
        if (wait_q == 2'(READ_LATENCY - 1)) begin
          len_d   = bram_portb_dout[LEN_MSB:0];
          state_d = bram_portb_dout[HDR_VALID_BIT] ? S_CHECK : S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (len_ok) begin
          err_d     = 1'b0;
          busy_d    = 1'b1;
          iss_cnt_d = '0;
          rcv_cnt_d = '0;
          state_d   = S_RD_PAY;
        end else begin
          err_d   = 1'b1;
          state_d = S_WR_STATUS;
        end
      end
      S_RD_PAY: begin
        if (pay_issue) iss_cnt_d = iss_cnt_q + 1'b1;
        if (acc_en) begin
          rcv_cnt_d = rcv_cnt_q + 1'b1;
          if (rcv_cnt_q == len_q - 1'b1) state_d = S_WR_SUM;
        end
      end
      S_WR_SUM: begin
        led_d   = sum[3:0];
        state_d = S_WR_XOR;
      end
      S_WR_XOR:    state_d = S_WR_STATUS;
      S_WR_STATUS: state_d = S_CLR_HDR;
      S_CLR_HDR: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Rejected requests report a zero word count alongside the error flag.
  always_comb begin
    status_w                  = '0;
    status_w[STATUS_DONE_BIT] = 1'b1;
    status_w[STATUS_ERR_BIT]  = err_q;
    if (!err_q) status_w[LEN_MSB:0] = len_q;
  end

  always_comb begin
    bram_portb_addr = '0;
    bram_portb_en   = 1'b0;
    bram_portb_we   = 1'b0;
    bram_portb_din  = '0;
    unique case (state_q)
      S_RD_HDR: begin
        bram_portb_en   = 1'b1;
        bram_portb_addr = ADDR_WIDTH'(HDR_ADDR);
      end
      S_RD_PAY: begin
        bram_portb_en   = pay_issue;
        bram_portb_addr = ADDR_WIDTH'(iss_cnt_q) + 1'b1;
      end
      S_WR_SUM: begin
        bram_portb_en   = 1'b1;
        bram_portb_we   = 1'b1;
        bram_portb_addr = RESP_BASE + ADDR_WIDTH'(RESP_SUM_OFS);
        bram_portb_din  = sum;
      end
      S_WR_XOR: begin
        bram_portb_en   = 1'b1;
        bram_portb_we   = 1'b1;
        bram_portb_addr = RESP_BASE + ADDR_WIDTH'(RESP_XOR_OFS);
        bram_portb_din  = xr;
      end
      S_WR_STATUS: begin
        bram_portb_en   = 1'b1;
        bram_portb_we   = 1'b1;
        bram_portb_addr = RESP_BASE + ADDR_WIDTH'(RESP_STATUS_OFS);
        bram_portb_din  = status_w;
      end
      S_CLR_HDR: begin
        bram_portb_en   = 1'b1;
        bram_portb_we   = 1'b1;
        bram_portb_addr = ADDR_WIDTH'(HDR_ADDR);
      end
      default: ;
    endcase
  end

  assign busy    = busy_q;
  assign done    = (state_q == S_CLR_HDR);
  assign err     = err_q;
  assign led_out = led_q;

endmodule

// File: tb/tb_bram_mailbox_reader.sv
// tb/tb_bram_mailbox_reader.sv - both read latencies side by side against a request-level mailbox model
module tb_bram_mailbox_reader;

  localparam int POLL = 16;
  localparam int MAXL = 1023;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [10:0] b_addr [2];
  logic        b_en   [2];
  logic        b_we   [2];
  logic [31:0] b_din  [2];
  logic [31:0] b_dout [2];
  logic        busy   [2];
  logic        done   [2];
  logic        err    [2];
  logic [3:0]  led    [2];

  bram_mailbox_reader #(
    .ADDR_WIDTH(11), .DATA_WIDTH(32), .READ_LATENCY(1), .RESP_BASE(11'h400),
    .MAX_LEN(MAXL), .POLL_INTERVAL(POLL)
  ) u_dut_rl1 (
    .clk(clk), .rst(rst),
    .bram_portb_addr(b_addr[0]), .bram_portb_en(b_en[0]), .bram_portb_we(b_we[0]),
    .bram_portb_din(b_din[0]), .bram_portb_dout(b_dout[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .led_out(led[0])
  );

  bram_mailbox_reader #(
    .ADDR_WIDTH(11), .DATA_WIDTH(32), .READ_LATENCY(2), .RESP_BASE(11'h400),
    .MAX_LEN(MAXL), .POLL_INTERVAL(POLL)
  ) u_dut_rl2 (
    .clk(clk), .rst(rst),
    .bram_portb_addr(b_addr[1]), .bram_portb_en(b_en[1]), .bram_portb_we(b_we[1]),
    .bram_portb_din(b_din[1]), .bram_portb_dout(b_dout[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .led_out(led[1])
  );

  // Dual-port BRAM per DUT: port A is the producer, port B the DUT.
  logic [31:0] mem [2][2048];
  logic [31:0] rd1 [2];
  logic [31:0] rd2 [2];
  logic        ps_we;
  logic [10:0] ps_addr;
  logic [31:0] ps_data;

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (ps_we) mem[g][ps_addr] <= ps_data;
      if (b_en[g]) begin
        if (b_we[g]) mem[g][b_addr[g]] <= b_din[g];
        rd1[g] <= mem[g][b_addr[g]];
      end
      rd2[g] <= rd1[g];
    end
  end
  assign b_dout[0] = rd1[0];
  assign b_dout[1] = rd2[1];

  logic [42:0] wr_q [2][$];
  int done_cnt [2] = '{0, 0};
  int pay_rd   [2] = '{0, 0};
  int busy_cyc [2] = '{0, 0};
  int bad_we   [2] = '{0, 0};

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (b_en[g] && b_we[g]) wr_q[g].push_back({b_addr[g], b_din[g]});
      if (b_en[g] && !b_we[g] && b_addr[g] != 11'd0) pay_rd[g]++;
      if (b_we[g] && !b_en[g]) bad_we[g]++;
      if (busy[g]) busy_cyc[g]++;
      if (done[g]) done_cnt[g]++;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ps_write(input logic [10:0] a, input logic [31:0] d);
    ps_we   = 1'b1;
    ps_addr = a;
    ps_data = d;
    tick();
    ps_we   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    for (int g = 0; g < 2; g++)
      check($sformatf("%s rl%0d outputs", name, g + 1),
            {b_en[g], b_we[g], b_addr[g], b_din[g], busy[g], done[g], err[g], led[g]}, 64'd0);
  endtask

  logic [31:0] pay_q [$];
  logic        exp_err = 1'b0;
  logic [3:0]  exp_led = 4'd0;

  task automatic run_req(input string name, input logic [31:0] hdr, input bit do_rst);
    logic [42:0] exp_q [$];
    int          ws [2];
    int          dc [2];
    int          pr [2];
    int          bc [2];
    int          len;
    int          got_n;
    int          t;
    bit          valid;
    bit          ok;
    logic [31:0] s;
    logic [31:0] x;

    valid = hdr[31];
    len   = int'(hdr[10:0]);
    ok    = valid && (len != 0) && (len <= MAXL);
    s = 32'd0;
    x = 32'd0;
    if (ok) begin
      for (int i = 0; i < len; i++) begin
        s = s + pay_q[i];
        x = x ^ pay_q[i];
      end
      exp_q.push_back({11'h400, s});
      exp_q.push_back({11'h401, x});
      exp_q.push_back({11'h402, 32'h8000_0000 | 32'(len)});
    end else if (valid) begin
      exp_q.push_back({11'h402, 32'hC000_0000});
    end
    if (valid) exp_q.push_back({11'h000, 32'h0});

    for (int g = 0; g < 2; g++) begin
      ws[g] = wr_q[g].size();
      dc[g] = done_cnt[g];
      pr[g] = pay_rd[g];
      bc[g] = busy_cyc[g];
    end

    for (int i = 0; i < pay_q.size(); i++) ps_write(11'(i + 1), pay_q[i]);
    ps_write(11'd0, hdr);

    if (do_rst) begin
      t = 0;
      while (!(busy[0] && busy[1]) && t < 4 * POLL + 40) begin
        tick();
        t++;
      end
      check($sformatf("%s both busy before reset", name), {31'd0, busy[0] && busy[1]}, 32'd1);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      for (int g = 0; g < 2; g++) begin
        check($sformatf("%s rl%0d busy after reset", name, g + 1), busy[g], 1'b0);
        check($sformatf("%s rl%0d we after reset", name, g + 1), b_we[g], 1'b0);
      end
      rst = 1'b0;
      exp_err = 1'b0;
      exp_led = 4'd0;
    end

    if (valid) begin
      for (int g = 0; g < 2; g++) begin
        t = 0;
        while (done_cnt[g] == dc[g] && t < len + 4 * POLL + 60) begin
          tick();
          t++;
        end
      end
    end else begin
      repeat (3 * (POLL + 4)) tick();
    end
    repeat (4) tick();

    if (ok) begin
      exp_err = 1'b0;
      exp_led = s[3:0];
    end else if (valid) begin
      exp_err = 1'b1;
    end

    for (int g = 0; g < 2; g++) begin
      got_n = wr_q[g].size() - ws[g];
      check($sformatf("%s rl%0d write count", name, g + 1), got_n, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_n; i++)
        check($sformatf("%s rl%0d write[%0d] {addr,data}", name, g + 1, i), wr_q[g][ws[g] + i], exp_q[i]);
      check($sformatf("%s rl%0d done pulses", name, g + 1), done_cnt[g] - dc[g], valid ? 1 : 0);
      if (!do_rst) begin
        check($sformatf("%s rl%0d payload reads", name, g + 1), pay_rd[g] - pr[g], ok ? len : 0);
        if (ok || !valid)
          check($sformatf("%s rl%0d busy cycles", name, g + 1), busy_cyc[g] - bc[g],
                ok ? len + (g + 1) + 4 : 0);
      end
      check($sformatf("%s rl%0d err", name, g + 1), err[g], exp_err);
      check($sformatf("%s rl%0d led_out", name, g + 1), led[g], exp_led);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [10:0] rl;
    rst     = 1'b1;
    ps_we   = 1'b0;
    ps_addr = 11'd0;
    ps_data = 32'd0;
    tick();
    ps_write(11'd0, 32'd0);
    repeat (2) tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    pay_q = '{32'd1, 32'd2, 32'd3};
    run_req("t1 len3", 32'h8000_0003, 1'b0);

    pay_q.delete();
    run_req("t2 len0", 32'h8000_0000, 1'b0);
    run_req("t3 len1024", 32'h8000_0400, 1'b0);

    pay_q.delete();
    for (int i = 0; i < MAXL; i++) pay_q.push_back(32'hFFFF_FFFF);
    run_req("t4 len1023", 32'h8000_03FF, 1'b0);

    pay_q.delete();
    run_req("t5 invalid", 32'h0000_0005, 1'b0);

    for (int r = 0; r < 6; r++) begin
      pay_q.delete();
      if (r % 3 == 2) begin
        rl = 11'($urandom_range(1024, 2047));
      end else begin
        rl = 11'($urandom_range(1, 40));
        for (int i = 0; i < int'(rl); i++) pay_q.push_back($urandom);
      end
      run_req($sformatf("rand%0d", r), {1'b1, 20'($urandom), rl}, 1'b0);
    end

    rst = 1'b1;
    repeat (2) tick();
    check_reset_outputs("realign reset");
    rst = 1'b0;
    exp_err = 1'b0;
    exp_led = 4'd0;

    pay_q.delete();
    for (int i = 0; i < 8; i++) pay_q.push_back($urandom);
    run_req("t6 reset mid-payload", 32'h8000_0008, 1'b1);

    for (int g = 0; g < 2; g++)
      check($sformatf("rl%0d we without en", g + 1), bad_we[g], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
